// File: rtl/conv_line_engine.sv
// conv_line_engine: KSIZE x KSIZE streaming 2D convolution over raster-order pixels, one result per complete window.
// Define CONV_RELU_EN to clamp negative saturated results to zero.
module conv_line_engine #(
  parameter int KSIZE = 5,
  parameter int IMG_W = 32,
  parameter int DW    = 8,
  parameter int OW    = 16,
  parameter int AW    = $clog2(KSIZE*KSIZE)
) (
  input  logic                 iCLK,
  input  logic                 iRST,
  input  logic                 iWren,
  input  logic [AW-1:0]        iADDR,
  input  logic signed [DW-1:0] iW,
  input  logic                 iValid,
  input  logic                 iSOF,
  input  logic signed [DW-1:0] iX,
  output logic                 oValid,
  output logic signed [OW-1:0] oY
);
  localparam int KK   = KSIZE*KSIZE;
  localparam int ACCW = 2*DW + $clog2(KK);
  localparam int CW   = $clog2(IMG_W);
  localparam int RW   = $clog2(KSIZE);
  logic signed [DW-1:0]   w_q [KK];
  logic signed [DW-1:0]   w_d [KK];
  logic signed [DW-1:0]   win_q [KSIZE][KSIZE];
  logic signed [DW-1:0]   win_d [KSIZE][KSIZE];
  logic signed [DW-1:0]   lb_q [KSIZE-1][IMG_W];
  logic signed [DW-1:0]   col_new [KSIZE];
  logic [CW-1:0]          col_q, col_d, col_e;
  logic [RW-1:0]          row_q, row_d, row_e;
  logic                   last_col, valid_q, valid_d;
  logic signed [ACCW-1:0] acc;
  logic [ACCW-OW:0]       acc_hi;
  logic signed [OW-1:0]   sat_y, y_q, y_d;
  always_comb begin
    w_d = w_q;
    if (iWren && 32'(iADDR) < KK) w_d[iADDR] = iW;
  end
  // A start-of-frame pixel overrides the tracked position before anything else uses it.
  always_comb begin
    col_e    = iSOF ? '0 : col_q;
    row_e    = iSOF ? '0 : row_q;
    last_col = col_e == CW'(IMG_W-1);
    for (int i = 0; i < KSIZE-1; i++) col_new[i] = lb_q[i][col_e];
    col_new[KSIZE-1] = iX;
    col_d = iValid ? (last_col ? '0 : col_e + CW'(1)) : col_q;
    row_d = !iValid ? row_q : (last_col && row_e != RW'(KSIZE-1)) ? row_e + RW'(1) : row_e;
    win_d = win_q;
    if (iValid)
      for (int i = 0; i < KSIZE; i++) begin
        for (int j = 0; j < KSIZE-1; j++) win_d[i][j] = win_q[i][j+1];
        win_d[i][KSIZE-1] = col_new[i];
      end
    valid_d = iValid && row_e == RW'(KSIZE-1) && col_e >= CW'(KSIZE-1);
  end
  // The sum uses the incoming window so the result lands one cycle after the completing pixel.
  always_comb begin
    acc = '0;
    for (int i = 0; i < KSIZE; i++)
      for (int j = 0; j < KSIZE; j++)
        acc = acc + ACCW'(w_q[i*KSIZE+j]) * ACCW'(win_d[i][j]);
    acc_hi = acc[ACCW-1:OW-1];
    sat_y  = (&acc_hi || ~|acc_hi) ? acc[OW-1:0] : {acc[ACCW-1], {(OW-1){~acc[ACCW-1]}}};
`ifdef CONV_RELU_EN
    y_d = valid_d ? (sat_y[OW-1] ? '0 : sat_y) : y_q;
`else
    y_d = valid_d ? sat_y : y_q;
`endif
  end
  always_ff @(posedge iCLK or posedge iRST) begin
    if (iRST) begin
      for (int k = 0; k < KK; k++) w_q[k] <= '0;
      for (int i = 0; i < KSIZE; i++)
        for (int j = 0; j < KSIZE; j++) win_q[i][j] <= '0;
      col_q   <= '0;
      row_q   <= '0;
      valid_q <= 1'b0;
      y_q     <= '0;
    end else begin
      w_q     <= w_d;
      win_q   <= win_d;
      col_q   <= col_d;
      row_q   <= row_d;
      valid_q <= valid_d;
      y_q     <= y_d;
    end
  end
  // Line buffers are never reset; the row/column mask keeps stale entries out of valid results.
  always_ff @(posedge iCLK) begin
    if (iValid)
      for (int i = 0; i < KSIZE-1; i++) lb_q[i][col_e] <= col_new[i+1];
  end
  assign oValid = valid_q;
  assign oY     = y_q;
endmodule

// File: tb/tb_conv_line_engine.sv
// tb_conv_line_engine: directed, table-driven checks of conv_line_engine against a direct convolution model.
module tb_conv_line_engine;
`ifdef CONV_RELU_EN
  localparam bit RELU = 1'b1;
`else
  localparam bit RELU = 1'b0;
`endif
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;
  logic              wren, vld, sof, ov;
  logic [3:0]        addr;
  logic signed [7:0] w, x;
  logic signed [15:0] oy;
  logic              wren5, vld5, sof5, ov5;
  logic [4:0]        addr5;
  logic signed [7:0] w5, x5;
  logic signed [15:0] oy5;
  conv_line_engine #(.KSIZE(3), .IMG_W(8)) u3 (
    .iCLK(clk), .iRST(rst), .iWren(wren), .iADDR(addr), .iW(w), .iValid(vld),
    .iSOF(sof), .iX(x), .oValid(ov), .oY(oy));
  conv_line_engine #(.KSIZE(5), .IMG_W(5)) u5 (
    .iCLK(clk), .iRST(rst), .iWren(wren5), .iADDR(addr5), .iW(w5), .iValid(vld5),
    .iSOF(sof5), .iX(x5), .oValid(ov5), .oY(oy5));
  typedef struct {int wv; int pv; int ey;} vec_t;
  vec_t tbl[8];
  vec_t tbl5[3];
  int wt[9];
  int img[8][8];
  int n_cmp = 0;
  int n_bad = 0;
  int n;
  task automatic chk(input string nm, input logic signed [31:0] act, input logic signed [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask
  function automatic int rl(input int v);
    return (RELU && v < 0) ? 0 : v;
  endfunction
  function automatic int conv3(input int r, input int c);
    longint s = 0;
    for (int i = 0; i < 3; i++)
      for (int j = 0; j < 3; j++) s += longint'(wt[i*3+j]) * img[r-2+i][c-2+j];
    if (s > 32767) s = 32767;
    if (s < -32768) s = -32768;
    return rl(int'(s));
  endfunction
  task automatic push3(input bit v, input bit s, input int px);
    vld = v; sof = s; x = 8'(px);
    @(posedge clk); #1;
    vld = 0; sof = 0; wren = 0;
  endtask
  task automatic wr3(input int a, input int val);
    wren = 1; addr = 4'(a); w = 8'(val);
    @(posedge clk); #1;
    wren = 0;
  endtask
  task automatic loadw3(input int val);
    for (int k = 0; k < 9; k++) begin
      wt[k] = val;
      wr3(k, val);
    end
  endtask
  task automatic fill(input bit ramp, input int pv);
    for (int r = 0; r < 8; r++)
      for (int c = 0; c < 8; c++) img[r][c] = ramp ? r*8 + c : pv;
  endtask
  task automatic frame3(input string nm, input int npix, input bit first_sof,
                        input int stall_at, input int sof_at, output int cnt);
    int r = 0, c = 0, last_exp = 0;
    bit ev;
    cnt = 0;
    for (int k = 0; k < npix; k++) begin
      if (k == stall_at)
        for (int s = 0; s < 3; s++) begin
          push3(0, 0, 0);
          chk({nm, " stall valid"}, ov, 0);
          chk({nm, " stall hold"}, oy, last_exp);
        end
      if (k == sof_at) begin r = 0; c = 0; end
      push3(1, (k == 0 && first_sof) || k == sof_at, img[r][c]);
      ev = r >= 2 && c >= 2;
      chk({nm, " valid"}, ov, ev);
      if (ev) begin
        last_exp = conv3(r, c);
        chk({nm, " y"}, oy, last_exp);
        cnt++;
      end
      c++;
      if (c == 8) begin c = 0; r++; end
    end
  endtask
  task automatic frame5(input int wv, input int pv, input int ey);
    for (int k = 0; k < 25; k++) begin
      wren5 = 1; addr5 = 5'(k); w5 = 8'(wv);
      @(posedge clk); #1;
      wren5 = 0;
    end
    for (int k = 0; k < 25; k++) begin
      vld5 = 1; sof5 = (k == 0); x5 = 8'(pv);
      @(posedge clk); #1;
      vld5 = 0; sof5 = 0;
      chk("k5 valid", ov5, k == 24);
    end
    chk("k5 y", oy5, rl(ey));
  endtask
  initial begin
    tbl[0] = '{1, 1, 9};
    tbl[1] = '{2, 3, 54};
    tbl[2] = '{-1, 1, -9};
    tbl[3] = '{127, 127, 32767};
    tbl[4] = '{-128, 127, -32768};
    tbl[5] = '{-3, -7, 189};
    tbl[6] = '{0, 100, 0};
    tbl[7] = '{5, -20, -900};
    tbl5[0] = '{127, 127, 32767};
    tbl5[1] = '{-128, 127, -32768};
    tbl5[2] = '{1, 2, 50};
    rst = 1; wren = 0; addr = 0; w = 0; vld = 0; sof = 0; x = 0;
    wren5 = 0; addr5 = 0; w5 = 0; vld5 = 0; sof5 = 0; x5 = 0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset valid", ov, 0);
    chk("reset y", oy, 0);
    chk("reset k5 valid", ov5, 0);
    rst = 0;
    for (int t = 0; t < 8; t++) begin
      loadw3(tbl[t].wv);
      fill(0, tbl[t].pv);
      frame3("const", 64, 1, -1, -1, n);
      chk("const count", n, 36);
      chk("const last y", oy, rl(tbl[t].ey));
    end
    for (int k = 0; k < 9; k++) begin
      wt[k] = k - 4;
      wr3(k, k - 4);
    end
    fill(1, 0);
    frame3("stall", 64, 1, 28, -1, n);
    chk("stall count", n, 36);
    loadw3(1);
    fill(0, 1);
    frame3("wtime pre", 18, 1, -1, -1, n);
    wren = 1; addr = 4'd8; w = 8'sd3;
    push3(1, 0, 1);
    chk("wtime same-cycle valid", ov, 1);
    chk("wtime same-cycle y", oy, 9);
    push3(1, 0, 1);
    chk("wtime next y", oy, 11);
    loadw3(1);
    wr3(9, 5);
    wr3(15, -7);
    fill(1, 0);
    frame3("oor sof", 66, 1, -1, 42, n);
    chk("oor sof count", n, 24);
    loadw3(2);
    fill(0, 1);
    frame3("prerst", 35, 1, -1, -1, n);
    chk("prerst y", oy, 18);
    #2;
    rst = 1;
    #1;
    chk("async rst valid", ov, 0);
    chk("async rst y", oy, 0);
    @(posedge clk); #1;
    rst = 0;
    for (int k = 0; k < 9; k++) wt[k] = 0;
    frame3("post rst nosof", 24, 0, -1, -1, n);
    chk("post rst count", n, 6);
    loadw3(1);
    frame3("restart", 24, 1, -1, -1, n);
    chk("restart count", n, 6);
    for (int t = 0; t < 3; t++) frame5(tbl5[t].wv, tbl5[t].pv, tbl5[t].ey);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/conv_line_engine.md
CONV_LINE_ENGINE -- requirements
Module: conv_line_engine

Interface
REQ-001 SHALL provide parameter KSIZE, default 5: kernel edge length, legal 2..7.
REQ-002 SHALL provide parameter IMG_W, default 32: pixels per image row, legal KSIZE..1024.
REQ-003 SHALL provide parameter DW, default 8: signed pixel and weight width.
REQ-004 SHALL provide parameter OW, default 16: signed output width, legal ≤ accumulator width.
REQ-005 SHALL provide derived parameter AW = $clog2(KSIZE*KSIZE): weight address width.
REQ-006 iCLK  input  1  sole clock; all state updates on rising edge.
REQ-007 iRST  input  1  asynchronous, active-high reset.
REQ-008 iWren  input  1  weight write strobe.
REQ-009 iADDR  input  AW  weight index, row-major: i*KSIZE+j.
REQ-010 iW  input  DW  signed weight data.
REQ-011 iValid  input  1  pixel-accept qualifier for iX and iSOF.
REQ-012 iSOF  input  1  start of frame; meaningful only with iValid=1.
REQ-013 iX  input  DW  signed pixel, raster order, row-major.
REQ-014 oValid  output  1  oY holds a complete window result.
REQ-015 oY  output  OW  signed saturated convolution result.

Function
REQ-016 SHALL store KSIZE*KSIZE weights; iWren=1 with iADDR<KSIZE*KSIZE writes W[iADDR]=iW; iADDR≥KSIZE*KSIZE SHALL be ignored.
REQ-017 A weight write SHALL affect results from the next accepted pixel onward; simultaneous write and accept SHALL use the old weight for that pixel.
REQ-018 SHALL advance all pixel state (line buffers, window, counters) only on cycles with iValid=1; iValid=0 SHALL freeze state and drive oValid=0 next cycle.
REQ-019 SHALL hold KSIZE-1 line buffers of IMG_W entries plus a KSIZE×KSIZE window register array.
REQ-020 SHALL keep column counter col (0..IMG_W-1, wraps to 0 and increments row) and row counter row (saturates at KSIZE-1).
REQ-021 Accepted pixel with iSOF=1 SHALL be treated as (row=0,col=0); counters restart from it regardless of prior position.
REQ-022 For accepted pixel at (row,col) with row≥KSIZE-1 and col≥KSIZE-1, the next cycle SHALL present oValid=1 and oY=sat(Σ W[i*KSIZE+j]·X(r-KSIZE+1+i, c-KSIZE+1+j)); otherwise oValid=0.
REQ-023 Latency SHALL be exactly 1 cycle from accepting the window-completing pixel to oValid.
REQ-024 Products SHALL be 2*DW bits signed; accumulator SHALL be 2*DW+$clog2(KSIZE*KSIZE) bits with no intermediate overflow.
REQ-025 sat() SHALL clamp to [-2^(OW-1), 2^(OW-1)-1].
REQ-026 oY SHALL hold its last value while oValid=0.
REQ-027 Windows straddling a row wrap SHALL never assert oValid.

Reset
REQ-028 iRST=1 SHALL immediately clear: oValid=0, oY=0, all weights=0, col=0, row=0, window registers=0.
REQ-029 Line buffer contents need not reset; REQ-022 masking SHALL prevent stale data reaching oValid=1.
REQ-030 Reset mid-frame SHALL discard the frame; the first pixel after release SHALL be (0,0) even without iSOF.

Configuration
REQ-031 With CONV_RELU_EN defined, oY SHALL be max(0, sat(sum)); without it oY SHALL be sat(sum) unmodified.
REQ-032 The macro SHALL not change latency, ports or oValid timing.

Verification
REQ-033 KSIZE=3, IMG_W=8, all weights 1, all pixels 1, one frame of 64 -> first oValid one cycle after pixel (2,2), oY=9, exactly 36 oValid pulses.
REQ-034 KSIZE=5, weights 127, pixels 127 -> oY=32767; weights -128, pixels 127 -> oY=-32768.
REQ-035 KSIZE=3, ramp pixels, iValid low 3 cycles at (3,4) -> oY sequence identical to unstalled run, oValid=0 during stall.
REQ-036 KSIZE=3, iRST asserted at (4,3) -> oValid=0, oY=0 immediately; reload weights, restart frame, first output after (2,2) again.
REQ-037 KSIZE=3, write iADDR=9 value 5 -> no weight changes; iSOF at (5,2) -> counters restart, no oValid until new (2,2).
REQ-038 KSIZE=3, weights -1, pixels 1 -> oY=0 with CONV_RELU_EN, oY=-9 without.
